// File: rtl/motor_cmd_sequencer_pkg.sv
// Shared types and defaults for the motor command sequencer.
// Contents: FSM state encoding, direction pair constants (bit1 = IN1/fwd, bit0 = IN2/rev),
// default duty codes and a multi-hot helper used by the switch decoder.
package motor_cmd_pkg;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2,
      ST_DEAD = 2'd3
   } state_t;

   typedef logic [1:0] dir_t;
   localparam dir_t DIR_COAST = 2'b00;
   localparam dir_t DIR_FWD   = 2'b10;
   localparam dir_t DIR_REV   = 2'b01;

   localparam logic [7:0] DEF_DUTY_100 = 8'd255;
   localparam logic [7:0] DEF_DUTY_75  = 8'd192;
   localparam logic [7:0] DEF_DUTY_50  = 8'd128;
   localparam logic [7:0] DEF_DUTY_25  = 8'd64;

   // True when two or more bits are set (clearing the lowest set bit leaves something).
   function automatic logic multi_hot(input logic [7:0] v);
      return |(v & (v - 8'd1));
   endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Command bus between the switch bank and the PWM/L298 stage.
// Signals: sw (raw switches), duty, dir_fwd, dir_rev, cmd_valid (change strobe), fault.
// master drives the switches and observes the command; slave is the sequencer side.
interface motor_cmd_sequencer_if;
   logic [7:0] sw;
   logic [7:0] duty;
   logic       dir_fwd;
   logic       dir_rev;
   logic       cmd_valid;
   logic       fault;

   modport master (output sw, input duty, dir_fwd, dir_rev, cmd_valid, fault);
   modport slave  (input sw, output duty, dir_fwd, dir_rev, cmd_valid, fault);
endinterface

// File: rtl/motor_cmd_sequencer_sw_debounce.sv
// Two-flop synchronizer plus whole-vector debounce for a bank of switches.
// Ports: clk, rst (async active-high), raw[WIDTH-1:0] in, stable[WIDTH-1:0] out.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES of an unchanged vector before stable updates.
module sw_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt;

   // Any bit change restarts the whole-vector count; once the count reaches
   // its last value it parks there, so it never wraps into a false accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= cand;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Switch-to-motor command sequencer: debounce, decode, reversal dead-time interlock.
// Ports: W5 clock, U18 async active-high reset, bus (slave): sw in; duty/dir_fwd/dir_rev/cmd_valid/fault out.
// Latency: debounced vector to outputs 1 cycle; reversal inserts DEADTIME_CYCLES of coast. Optional macro MOTOR_SOFT_START_EN ramps duty up.
module motor_cmd_sequencer
   import motor_cmd_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 1000000,
   parameter int         DEADTIME_CYCLES = 5000000,
   parameter logic [7:0] DUTY_100        = DEF_DUTY_100,
   parameter logic [7:0] DUTY_75         = DEF_DUTY_75,
   parameter logic [7:0] DUTY_50         = DEF_DUTY_50,
   parameter logic [7:0] DUTY_25         = DEF_DUTY_25,
   parameter int         RAMP_CYCLES     = 100000
) (
   input  logic                  W5,
   input  logic                  U18,
   motor_cmd_sequencer_if.slave  bus
);

   if (DEBOUNCE_CYCLES < 2 || DEADTIME_CYCLES < 2 || RAMP_CYCLES < 1) begin : g_bad_param
      $error("motor_cmd_sequencer: cycle parameters out of range");
   end

   localparam int DW = $clog2(DEADTIME_CYCLES);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYCLES - 1);

   logic [7:0]    stable;
   state_t        req;
   logic [7:0]    req_duty;
   logic          req_fault;
   state_t        state, state_nxt;
   logic [DW-1:0] dead_cnt;
   logic [7:0]    duty_q, duty_nxt;
   dir_t          dir_q, dir_nxt;
   logic          cmd_valid_q;
   logic          fault_q;

   sw_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (W5),
      .rst    (U18),
      .raw    (bus.sw),
      .stable (stable)
   );

   // Only a strictly one-hot vector requests motion; zero or multi-hot falls to STOP.
   always_comb begin
      req       = ST_STOP;
      req_duty  = '0;
      req_fault = multi_hot(stable);
      case (stable)
         8'h01: begin req = ST_FWD; req_duty = DUTY_100; end
         8'h02: begin req = ST_FWD; req_duty = DUTY_75;  end
         8'h04: begin req = ST_FWD; req_duty = DUTY_50;  end
         8'h08: begin req = ST_FWD; req_duty = DUTY_25;  end
         8'h10: begin req = ST_REV; req_duty = DUTY_100; end
         8'h20: begin req = ST_REV; req_duty = DUTY_75;  end
         8'h40: begin req = ST_REV; req_duty = DUTY_50;  end
         8'h80: begin req = ST_REV; req_duty = DUTY_25;  end
         default: ;
      endcase
   end

   // Direction can only flip through DEAD; the dead-time count ignores req changes.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOP: state_nxt = req;
         ST_FWD:  state_nxt = (req == ST_REV) ? ST_DEAD : req;
         ST_REV:  state_nxt = (req == ST_FWD) ? ST_DEAD : req;
         ST_DEAD: if (dead_cnt == DEAD_LAST) state_nxt = req;
         default: state_nxt = ST_STOP;
      endcase
   end

`ifdef MOTOR_SOFT_START_EN
   localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

   logic [RW-1:0] ramp_cnt;
   logic          ramp_step;
   logic          run_nxt;

   assign ramp_step = (ramp_cnt == RAMP_LAST);
   assign run_nxt   = (state_nxt == ST_FWD) || (state_nxt == ST_REV);

   // Counts only while climbing towards a higher target; any other case rearms it.
   always_ff @(posedge W5 or posedge U18) begin
      if (U18) begin
         ramp_cnt <= '0;
      end else if (run_nxt && (req_duty > duty_q) && !ramp_step) begin
         ramp_cnt <= ramp_cnt + 1'b1;
      end else begin
         ramp_cnt <= '0;
      end
   end
`endif

   // Outputs are decoded from the next state so they register together with it.
   always_comb begin
      dir_nxt  = DIR_COAST;
      duty_nxt = '0;
      case (state_nxt)
         ST_FWD:  dir_nxt = DIR_FWD;
         ST_REV:  dir_nxt = DIR_REV;
         default: dir_nxt = DIR_COAST;
      endcase
      if (state_nxt == ST_FWD || state_nxt == ST_REV) begin
`ifdef MOTOR_SOFT_START_EN
         if (req_duty < duty_q) begin
            duty_nxt = req_duty;
         end else if ((req_duty > duty_q) && ramp_step) begin
            duty_nxt = duty_q + 8'd1;
         end else begin
            duty_nxt = duty_q;
         end
`else
         duty_nxt = req_duty;
`endif
      end
   end

   always_ff @(posedge W5 or posedge U18) begin
      if (U18) begin
         state       <= ST_STOP;
         dead_cnt    <= '0;
         duty_q      <= '0;
         dir_q       <= DIR_COAST;
         cmd_valid_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         duty_q      <= duty_nxt;
         dir_q       <= dir_nxt;
         cmd_valid_q <= (duty_nxt != duty_q) || (dir_nxt != dir_q);
         fault_q     <= req_fault;
         if (state == ST_DEAD && dead_cnt != DEAD_LAST) begin
            dead_cnt <= dead_cnt + 1'b1;
         end else begin
            dead_cnt <= '0;
         end
      end
   end

   assign bus.duty      = duty_q;
   assign bus.dir_fwd   = dir_q[1];
   assign bus.dir_rev   = dir_q[0];
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.fault     = fault_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench for motor_cmd_sequencer (DEBOUNCE 8, DEADTIME 16, RAMP 4, soft start off).
// Expected command events are queued when switches are driven and popped on each cmd_valid.
// Latencies are counted from the first clock edge that samples the new switch value.
module tb_motor_cmd_sequencer;

   localparam int DEB  = 8;
   localparam int DT   = 16;
   localparam int RAMP = 4;

   typedef struct packed {
      logic [7:0] duty;
      logic       fwd;
      logic       rev;
   } out_t;

   typedef struct {
      logic [7:0] sw;
      out_t       exp;
      bit         fault;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   motor_cmd_sequencer_if bus ();

   motor_cmd_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .DEADTIME_CYCLES (DT),
      .RAMP_CYCLES     (RAMP)
   ) dut (
      .W5  (clk),
      .U18 (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   evt_cnt = 0;
   int   last_evt_cyc = 0;
   int   both_dirs = 0;
   out_t exp_q[$];
   out_t model_prev;
   out_t mon_got;
   out_t mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic out_t mk(input int d, input bit f, input bit r);
      out_t o;
      o.duty = 8'(d);
      o.fwd  = f;
      o.rev  = r;
      return o;
   endfunction

   // Scoreboard side: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.dir_fwd && bus.dir_rev) both_dirs++;
      if (bus.cmd_valid) begin
         mon_got = mk(int'(bus.duty), bus.dir_fwd, bus.dir_rev);
         evt_cnt++;
         last_evt_cyc = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe got duty=%0d fwd=%0b rev=%0b, required no strobe",
                     mon_got.duty, mon_got.fwd, mon_got.rev);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_fail++;
               $display("FAIL cmd_event got duty=%0d fwd=%0b rev=%0b, required duty=%0d fwd=%0b rev=%0b",
                        mon_got.duty, mon_got.fwd, mon_got.rev, mon_exp.duty, mon_exp.fwd, mon_exp.rev);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   task automatic check_outs(input string name, input out_t e, input bit f);
      check({name, "_duty"}, int'(bus.duty), int'(e.duty));
      check({name, "_fwd"}, int'(bus.dir_fwd), int'(e.fwd));
      check({name, "_rev"}, int'(bus.dir_rev), int'(e.rev));
      check({name, "_fault"}, int'(bus.fault), int'(f));
   endtask

   // Reference behaviour: a fwd<->rev reversal shows a coast command first,
   // then the new command; otherwise one event only if the outputs change.
   task automatic push_model(input out_t nw);
      if ((model_prev.fwd && nw.rev) || (model_prev.rev && nw.fwd))
         exp_q.push_back(mk(0, 1'b0, 1'b0));
      if (nw != model_prev) exp_q.push_back(nw);
      model_prev = nw;
   endtask

   task automatic drive_sw(input logic [7:0] v, output int t0);
      @(posedge clk);
      #1;
      bus.sw = v;
      t0 = cyc;
   endtask

   task automatic wait_evt(input int budget, input string name, output int at);
      int start;
      start = evt_cnt;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (evt_cnt != start) begin
            at = last_evt_cyc;
            break;
         end
      end
      if (at < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout got no strobe in %0d cycles, required one", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      int   t0, t1, t2, at, ev0;

      tbl[0]  = '{8'h01, mk(255, 1, 0), 1'b0};
      tbl[1]  = '{8'h02, mk(192, 1, 0), 1'b0};
      tbl[2]  = '{8'h08, mk(64,  1, 0), 1'b0};
      tbl[3]  = '{8'h00, mk(0,   0, 0), 1'b0};
      tbl[4]  = '{8'h40, mk(128, 0, 1), 1'b0};
      tbl[5]  = '{8'h80, mk(64,  0, 1), 1'b0};
      tbl[6]  = '{8'h03, mk(0,   0, 0), 1'b1};
      tbl[7]  = '{8'h02, mk(192, 1, 0), 1'b0};
      tbl[8]  = '{8'h20, mk(192, 0, 1), 1'b0};
      tbl[9]  = '{8'h30, mk(0,   0, 0), 1'b1};
      tbl[10] = '{8'h01, mk(255, 1, 0), 1'b0};

      bus.sw     = 8'h00;
      model_prev = mk(0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_outs("reset", mk(0, 0, 0), 1'b0);
      check("reset_release_strobe", int'(bus.cmd_valid), 0);

      // Single forward 100 % switch: one strobe, 11 cycles after sampling.
      drive_sw(8'h01, t0);
      push_model(mk(255, 1, 0));
      wait_evt(30, "sw01", at);
      check("sw01_latency", at - (t0 + 1), 11);
      repeat (10) @(negedge clk);
      check("sw01_single_strobe", exp_q.size(), 0);
      check_outs("sw01", mk(255, 1, 0), 1'b0);

      // Asynchronous reset mid-cycle while running forward.
      @(negedge clk);
      #2;
      rst    = 1'b1;
      bus.sw = 8'h00;
      #1;
      check_outs("async_reset", mk(0, 0, 0), 1'b0);
      exp_q.delete();
      model_prev = mk(0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check_outs("after_reset_idle", mk(0, 0, 0), 1'b0);

      // Bouncing input: nothing accepted until it settles.
      ev0 = evt_cnt;
      for (int i = 0; i < 10; i++) begin
         drive_sw((i % 2 == 0) ? 8'h04 : 8'h00, t0);
         repeat (2) @(posedge clk);
      end
      drive_sw(8'h04, t0);
      check("bounce_no_strobe", evt_cnt - ev0, 0);
      check("bounce_duty_held", int'(bus.duty), 0);
      push_model(mk(128, 1, 0));
      wait_evt(30, "bounce_settle", at);
      check("bounce_settle_latency", at - (t0 + 1), 11);

      // Table of switch patterns, each held long enough to cover a reversal.
      for (int i = 0; i < 11; i++) begin
         drive_sw(tbl[i].sw, t0);
         push_model(tbl[i].exp);
         repeat (45) @(negedge clk);
         check($sformatf("vec%0d_events_done", i), exp_q.size(), 0);
         check_outs($sformatf("vec%0d", i), tbl[i].exp, tbl[i].fault);
      end

      // Reversal forward 100 % -> reverse 100 %: coast for exactly DT cycles.
      drive_sw(8'h10, t0);
      push_model(mk(255, 0, 1));
      wait_evt(30, "rev_coast", t1);
      check("rev_coast_latency", t1 - (t0 + 1), 11);
      repeat (8) @(negedge clk);
      check_outs("rev_mid_dead", mk(0, 0, 0), 1'b0);
      wait_evt(30, "rev_resume", t2);
      check("rev_dead_cycles", t2 - t1, DT);
      repeat (5) @(negedge clk);
      check("rev_events_done", exp_q.size(), 0);
      check_outs("rev_run", mk(255, 0, 1), 1'b0);

      // Reset during DEAD: immediate stop, then a straight re-debounce into reverse.
      drive_sw(8'h02, t0);
      push_model(mk(192, 1, 0));
      wait_evt(30, "dead_rst_coast", t1);
      repeat (3) @(negedge clk);
      bus.sw = 8'h20;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_outs("dead_rst_async", mk(0, 0, 0), 1'b0);
      exp_q.delete();
      model_prev = mk(0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      t0  = cyc;
      push_model(mk(192, 0, 1));
      wait_evt(30, "dead_rst_resume", at);
      check("dead_rst_latency", at - (t0 + 1), 11);
      repeat (25) @(negedge clk);
      check("dead_rst_no_dead", exp_q.size(), 0);
      check_outs("dead_rst_run", mk(192, 0, 1), 1'b0);

      check("never_both_dirs", both_dirs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Upstream command stage for the PWM motor driver. Synchronizes and debounces the eight speed/direction switches, then decodes them into a duty code plus direction pair. Enforces a coast dead-time interlock before any forward/reverse reversal. Outputs feed the PWM stage's pulse-width and L298 IN1/IN2 inputs directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the switch vector must be unchanged before acceptance (10 ms at 100 MHz).
DEADTIME_CYCLES, 5000000, coast cycles (duty 0, both dirs 0) on a direction reversal (50 ms).
DUTY_100, 255, duty code for sw0/sw4.
DUTY_75, 192, duty code for sw1/sw5.
DUTY_50, 128, duty code for sw2/sw6.
DUTY_25, 64, duty code for sw3/sw7.
RAMP_CYCLES, 100000, cycles per +1 duty step (used only with SOFT_START_EN).

Ports:
W5  in  1  100 MHz system clock; all logic on rising edge.
U18  in  1  reset, asynchronous, active-high (BTNC).
sw  in  8  raw switches; [3:0] forward 100/75/50/25 %, [7:4] reverse 100/75/50/25 %.
duty  out  8  pulse-width code to the PWM stage.
dir_fwd  out  1  L298 IN1 (K17).
dir_rev  out  1  L298 IN2 (M18).
cmd_valid  out  1  one-cycle strobe when duty, dir_fwd or dir_rev changes.
fault  out  1  high while more than one switch is active in the debounced vector.

Behaviour:
- Reset (async assert, sync release): sync flops, candidate and stable vectors = 0; debounce and dead-time counters = 0; state = STOP; duty = 0, dir_fwd = 0, dir_rev = 0, cmd_valid = 0, fault = 0.
- Sync: 2-flop synchronizer per switch bit.
- Debounce, whole-vector:
  - If synced != candidate: candidate <= synced, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= candidate, and the counter holds.
  - Else counter++.
  - Counter width is $clog2(DEBOUNCE_CYCLES) and never wraps.
- Decode of stable (combinational):
  - Zero bits set -> req STOP.
  - Exactly one bit set -> req FWD (bits 3:0) or REV (bits 7:4), with the matching DUTY_* code.
  - More than one bit set -> req STOP, and fault = 1 (registered).
- FSM states: STOP, FWD, REV, DEAD.
  - STOP: duty 0, dirs 00. req FWD/REV -> that state next cycle.
  - FWD: dir_fwd = 1, duty = requested level. A level change updates duty next cycle. req STOP -> STOP. req REV -> DEAD.
  - REV: mirror of FWD (dir_rev = 1). req FWD -> DEAD.
  - DEAD: duty 0, dirs 00, counts DEADTIME_CYCLES.
    - On expiry, go to the state matching the current req: FWD, REV or STOP.
    - A req change during DEAD does not restart the count.
- Invariants: dir_fwd & dir_rev is never 1. Direction never flips without passing through DEAD or STOP.
- Latency:
  - Stable to outputs: 1 cycle.
  - Raw switch to outputs: 2 + DEBOUNCE_CYCLES + 1 cycles when the input is clean.
  - A reversal adds DEADTIME_CYCLES.
- cmd_valid is registered alongside the outputs. It is never asserted in the cycle reset releases.
- Reset mid-DEAD or mid-run: immediate STOP outputs. After release, the commanded state is re-entered only after a full re-debounce.

Optional Feature:
MOTOR_SOFT_START_EN
- Defined: on entry to FWD/REV, or on an increase in requested level, duty ramps +1 every RAMP_CYCLES until it reaches the target. Decreases and STOP/DEAD apply immediately. cmd_valid strobes on each step.
- Undefined: duty jumps to the target. The ramp counter and RAMP_CYCLES are unused and generate no logic.

Decomposition:
- Package motor_cmd_pkg holds:
  - state encoding (STOP = 0, FWD = 1, REV = 2, DEAD = 3);
  - direction pair constants (COAST = 00, FWD = 10, REV = 01);
  - the DUTY_* defaults.
- One sub-module, sw_debounce (synchronizer plus whole-vector debounce), parameterized by width and DEBOUNCE_CYCLES, outputting stable[7:0].

Test Plan (DEBOUNCE_CYCLES = 8, DEADTIME_CYCLES = 16, RAMP_CYCLES = 4):
1. Assert U18 mid-cycle while running FWD -> duty = 0, dirs = 00, fault = 0 immediately, before the next clock edge.
2. sw = 0x01 held -> 11 cycles later: duty = 255, dir_fwd = 1, one cmd_valid pulse.
3. sw toggles 0x04/0x00 every 3 cycles for 30 cycles, then holds 0x04 -> no output change while toggling; then duty = 128, dir_fwd = 1, 11 cycles after the final edge.
4. Running FWD at 0x01, sw changes to 0x10 -> after debounce: duty 0, dirs 00 for 16 cycles; then dir_rev = 1, duty = 255; dir_fwd & dir_rev is never 1.
5. sw = 0x03 -> fault = 1, duty 0, STOP. Then sw = 0x02 -> fault = 0, duty = 192, dir_fwd = 1.
6. Pulse U18 during DEAD, with sw = 0x20 held -> STOP immediately; after release, 11 cycles later: dir_rev = 1, duty = 192, with no DEAD phase.
